// File: rtl/qpsk_burst_ctrl.sv
// QPSK burst sequencer: frames the serial bit stream into OFDM symbols with idle gaps and burst strobes.
// Optional build macro QPSK_FLUSH_PAD_EN: a mid-symbol flush pads the symbol out with zero bits.
module qpsk_burst_ctrl #(
  parameter int BITS_PER_SYM = 384,
  parameter int GAP_CYCLES   = 64,
  parameter int SYM_W        = 8
) (
  input  logic             clk_100,
  input  logic             Reset,
  input  logic             start,
  input  logic [SYM_W-1:0] num_sym,
  input  logic             flush,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             sym_start,
  output logic             sym_last,
  output logic             burst_done,
  output logic             flushed,
  output logic [SYM_W-1:0] sym_count
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | passing interleaver bits through to the modulator
  // GAP    | idle gap between symbols, upstream stalled
  // PAD    | flush pad: zero bits until the current symbol is complete
  // DONE   | one-cycle burst_done
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int BIT_W = (BITS_PER_SYM > 2) ? $clog2(BITS_PER_SYM) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_SYM - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]       state;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [SYM_W-1:0] sym_cnt;
  logic [SYM_W-1:0] len_q;
  logic             flush_q;

  logic             xfer;
  logic             in_sym;
  logic             is_last;
  logic [SYM_W-1:0] sym_inc;

  // Outputs are forced low while Reset is high, even though state only clears at the edge.
  always_comb begin
    ready_out = 1'b0;
    valid_out = 1'b0;
    data_out  = 1'b0;
    if (!Reset) begin
      if (state == S_RUN) begin
        ready_out = ready_in;
        valid_out = valid_in;
        data_out  = data_in;
      end else if (state == S_PAD) begin
        valid_out = 1'b1;
      end
    end
  end

  assign xfer       = valid_out & ready_in;
  assign in_sym     = (state == S_RUN) || (state == S_PAD);
  assign is_last    = (bit_cnt == BIT_LAST);
  assign sym_inc    = sym_cnt + SYM_W'(1);
  assign sym_start  = in_sym & xfer & (bit_cnt == '0);
  assign sym_last   = in_sym & xfer & is_last;
  assign busy       = !Reset && (state != S_IDLE);
  assign burst_done = !Reset && (state == S_DONE);
  assign flushed    = burst_done & flush_q;
  assign sym_count  = Reset ? '0 : sym_cnt;

`ifdef QPSK_FLUSH_PAD_EN
  logic [BIT_W-1:0] bit_nxt;
  assign bit_nxt = bit_cnt + BIT_W'(xfer);
`endif

  always_ff @(posedge clk_100) begin
    if (Reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sym_cnt <= '0;
      len_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sym_cnt <= '0;
            flush_q <= 1'b0;
            bit_cnt <= '0;
            if (num_sym != '0) begin
              len_q <= num_sym;
              state <= S_RUN;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (xfer)
            bit_cnt <= is_last ? '0 : bit_cnt + BIT_W'(1);
          // A completing symbol is counted before a same-cycle flush takes effect.
          if (xfer && is_last) begin
            sym_cnt <= sym_inc;
            if (flush || (sym_inc == len_q)) begin
              flush_q <= flush;
              state   <= S_DONE;
            end else if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else if (flush) begin
            flush_q <= 1'b1;
`ifdef QPSK_FLUSH_PAD_EN
            state   <= (bit_nxt != '0) ? S_PAD : S_DONE;
`else
            bit_cnt <= '0;
            state   <= S_DONE;
`endif
          end
        end
        S_GAP: begin
          if (flush) begin
            flush_q <= 1'b1;
            gap_cnt <= '0;
            state   <= S_DONE;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_RUN;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_PAD: begin
          if (xfer) begin
            if (is_last) begin
              bit_cnt <= '0;
              sym_cnt <= sym_inc;
              state   <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        S_DONE: begin
          bit_cnt <= '0;
          gap_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_burst_ctrl.sv
// Directed bench for qpsk_burst_ctrl (BITS_PER_SYM=8, GAP_CYCLES=3); optional QPSK_FLUSH_PAD_EN expectations.
module tb_qpsk_burst_ctrl;
  localparam int BPS = 8;
  localparam int GAP = 3;
  localparam int SW  = 8;

  logic          clk_100 = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] num_sym = '0;
  logic          flush = 1'b0;
  logic          data_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b0;
  logic          ready_out, data_out, valid_out, busy;
  logic          sym_start, sym_last, burst_done, flushed;
  logic [SW-1:0] sym_count;
  logic [15:0]   outs;

  int n_chk = 0;
  int n_fail = 0;
  int clr_id = 0;
  bit tog_data = 1'b1;

  // monitor-owned event record
  int seen_id = 0;
  int cyc_n, n_xfer, n_rdy, n_vout, n_busy, n_done, n_fl, done_cyc, done_sc, err_pt;
  int xfer_cyc [32];
  logic [31:0] rx, start_pos, last_pos;

  qpsk_burst_ctrl #(.BITS_PER_SYM(BPS), .GAP_CYCLES(GAP), .SYM_W(SW)) dut (
    .clk_100(clk_100), .Reset(Reset), .start(start), .num_sym(num_sym), .flush(flush),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy(busy), .sym_start(sym_start),
    .sym_last(sym_last), .burst_done(burst_done), .flushed(flushed), .sym_count(sym_count)
  );

  assign outs = {ready_out, data_out, valid_out, busy, sym_start, sym_last, burst_done, flushed, sym_count};

  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    if (seen_id != clr_id) begin
      seen_id = clr_id;
      cyc_n = 0; n_xfer = 0; n_rdy = 0; n_vout = 0; n_busy = 0; n_done = 0; n_fl = 0;
      done_cyc = -1; done_sc = -1; err_pt = 0; rx = '0; start_pos = '0; last_pos = '0;
      for (int i = 0; i < 32; i++) xfer_cyc[i] = -1;
    end
    if (valid_out && ready_in) begin
      if (n_xfer < 32) begin
        xfer_cyc[n_xfer]  = cyc_n;
        rx[n_xfer]        = data_out;
        start_pos[n_xfer] = sym_start;
        last_pos[n_xfer]  = sym_last;
      end
      if (ready_out && (data_out != data_in)) err_pt++;
      n_xfer++;
    end
    if (ready_out) n_rdy++;
    if (valid_out) n_vout++;
    if (busy) n_busy++;
    if (burst_done) begin
      n_done++;
      done_cyc = cyc_n;
      done_sc  = int'(sym_count);
    end
    if (flushed) n_fl++;
    cyc_n++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_100);
    #1;
    if (tog_data) data_in = ~data_in;
  endtask

  task automatic clr();
    clr_id++;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int k = 0; k < max_cyc && n_done == 0; k++) cyc();
  endtask

  task automatic begin_burst(input int len);
    clr();
    num_sym = SW'(len);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    cyc();
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk_100) check("reset_outs", int'(outs), 0);
    cyc();
    Reset = 1'b0;
    @(negedge clk_100) check("post_reset_outs", int'(outs), 0);
    cyc();

    // normal two-symbol burst, full throughput
    begin_burst(2);
    wait_done(40);
    repeat (2) cyc();
    check("norm_xfers", n_xfer, 16);
    check("norm_first_xfer_cyc", xfer_cyc[0], 1);
    check("norm_sym_start_pos", int'(start_pos[15:0]), 'h0101);
    check("norm_sym_last_pos", int'(last_pos[15:0]), 'h8080);
    check("norm_gap_span", xfer_cyc[8] - xfer_cyc[7], GAP + 1);
    check("norm_done_latency", done_cyc - xfer_cyc[15], 1);
    check("norm_done_count", n_done, 1);
    check("norm_flushed", n_fl, 0);
    check("norm_sym_count", done_sc, 2);
    check("norm_ready_cycles", n_rdy, 16);
    check("norm_valid_cycles", n_vout, 16);
    check("norm_busy_cycles", n_busy, 20);
    check("norm_passthrough_err", err_pt, 0);

    // backpressure: ready_in alternates 1,0 from the first RUN cycle
    ready_in = 1'b0;
    begin_burst(1);
    for (int i = 0; i < 40 && n_done == 0; i++) begin
      ready_in = ~ready_in;
      cyc();
    end
    repeat (2) begin
      ready_in = ~ready_in;
      cyc();
    end
    check("bp_xfers", n_xfer, 8);
    check("bp_span", xfer_cyc[7] - xfer_cyc[0], 14);
    check("bp_ready_cycles", n_rdy, 8);
    check("bp_valid_cycles", n_vout, 15);
    check("bp_sym_count", done_sc, 1);
    check("bp_passthrough_err", err_pt, 0);
    ready_in = 1'b1;

    // zero-length burst
    begin_burst(0);
    wait_done(10);
    cyc();
    check("zero_done_cyc", done_cyc, 1);
    check("zero_busy_cycles", n_busy, 1);
    check("zero_sym_count", done_sc, 0);
    check("zero_flushed", n_fl, 0);

    // start and num_sym changes mid-burst are ignored
    begin_burst(2);
    repeat (3) cyc();
    num_sym = SW'(5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(40);
    cyc();
    check("ign_xfers", n_xfer, 16);
    check("ign_sym_count", done_sc, 2);
    check("ign_done_count", n_done, 1);

    // flush mid-symbol after 3 transfers, flush cycle carries no transfer
    tog_data = 1'b0;
    data_in = 1'b1;
    begin_burst(4);
    repeat (3) cyc();
    valid_in = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_done(20);
    cyc();
`ifdef QPSK_FLUSH_PAD_EN
    check("fl_xfers", n_xfer, 8);
    check("fl_pad_bits", int'(rx[7:0]), 'h07);
    check("fl_sym_last_pos", int'(last_pos[7:0]), 'h80);
    check("fl_done_cyc", done_cyc, 10);
    check("fl_sym_count", done_sc, 1);
`else
    check("fl_xfers", n_xfer, 3);
    check("fl_done_cyc", done_cyc, 5);
    check("fl_sym_count", done_sc, 0);
`endif
    check("fl_flushed", n_fl, 1);
    check("fl_done_count", n_done, 1);
    valid_in = 1'b1;
    tog_data = 1'b1;

    // next burst after a flush starts cleanly from bit 0
    begin_burst(1);
    wait_done(20);
    cyc();
    check("post_fl_start_pos", int'(start_pos[7:0]), 'h01);
    check("post_fl_last_pos", int'(last_pos[7:0]), 'h80);
    check("post_fl_sym_count", done_sc, 1);

    // flush during the gap after symbol 1
    begin_burst(3);
    repeat (9) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_done(10);
    repeat (2) cyc();
    check("gapfl_done_cyc", done_cyc, 11);
    check("gapfl_xfers", n_xfer, 8);
    check("gapfl_ready_cycles", n_rdy, 8);
    check("gapfl_flushed", n_fl, 1);
    check("gapfl_sym_count", done_sc, 1);

    // synchronous reset on the 5th bit of symbol 2
    begin_burst(3);
    repeat (15) cyc();
    Reset = 1'b1;
    @(negedge clk_100) check("midrst_outs", int'(outs), 0);
    cyc();
    Reset = 1'b0;
    @(negedge clk_100) check("midrst_after_outs", int'(outs), 0);
    repeat (3) cyc();
    check("midrst_xfers", n_xfer, 12);
    check("midrst_no_done", n_done, 0);

    begin_burst(1);
    wait_done(20);
    cyc();
    check("clean_xfers", n_xfer, 8);
    check("clean_start_pos", int'(start_pos[7:0]), 'h01);
    check("clean_last_pos", int'(last_pos[7:0]), 'h80);
    check("clean_sym_count", done_sc, 1);
    check("clean_passthrough_err", err_pt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
